// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolve path: FSM states, instruction
// size and queue entry field widths.
package branch_resolve_pkg;

  typedef enum logic [0:0] {
    BR_RES_RUN   = 1'b0,
    BR_RES_FLUSH = 1'b1
  } br_res_state_e;

  localparam int INSN_BYTES = 4;
  localparam int TAKEN_W    = 1;

  // Queue entry is {pc, taken, target}.
  function automatic int entry_w(input int xlen);
    return xlen + TAKEN_W + xlen;
  endfunction

endpackage

// File: rtl/branch_resolve_pred_fifo.sv
// pred_fifo: synchronous FIFO with clear, full/empty flags and no bypass.
// A pop never frees a slot for a push in the same cycle.
module pred_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/branch_resolve.sv
// Queues static branch predictions and checks them in order against execute;
// a mispredict flushes the queue and pulses redirect/flush for one cycle.
// Optional statistics counters: define BRANCH_RESOLVE_STATS_EN.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pred_valid,
  output logic            pred_ready,
  input  logic [XLEN-1:0] pred_pc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispredict
`endif
);

  localparam int ENTRY_W = entry_w(XLEN);

  br_res_state_e    state_q, state_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [ENTRY_W-1:0] head;
  logic [XLEN-1:0]  head_pc, head_target;
  logic             head_taken;
  logic             fifo_full, fifo_empty;
  logic             res_fire, mispredict, do_pop, do_clr;

  assign {head_pc, head_taken, head_target} = head;

  assign pred_ready  = (state_q == BR_RES_RUN) && !fifo_full;
  assign res_ready   = (state_q == BR_RES_RUN) && !fifo_empty;
  assign redirect    = (state_q == BR_RES_FLUSH);
  assign flush       = (state_q == BR_RES_FLUSH);
  assign redirect_pc = redirect_pc_q;

  assign res_fire   = res_valid && res_ready;
  assign mispredict = (head_taken != res_taken) ||
                      (res_taken && (head_target != res_target));
  assign do_pop     = res_fire && !mispredict;
  assign do_clr     = res_fire && mispredict;

  // A push coinciding with a mispredict is wrong-path; the clear drops it.
  pred_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_pred_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (do_clr),
    .push  (pred_valid && pred_ready),
    .pop   (do_pop),
    .wdata ({pred_pc, pred_taken, pred_target}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      BR_RES_RUN: begin
        if (do_clr) begin
          state_d       = BR_RES_FLUSH;
          redirect_pc_d = res_taken ? res_target : head_pc + XLEN'(INSN_BYTES);
        end
      end
      BR_RES_FLUSH: state_d = BR_RES_RUN;
      default:      state_d = BR_RES_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BR_RES_RUN;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispredict_q, stat_mispredict_d;

  always_comb begin
    stat_resolved_d   = stat_resolved_q + 32'(res_fire);
    stat_mispredict_d = stat_mispredict_q + 32'(do_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_resolved_q   <= stat_resolved_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign stat_resolved   = stat_resolved_q;
  assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_branch_resolve;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, res_valid, res_taken;
  logic [31:0] pred_pc, pred_target, res_target;
  logic        pred_ready, res_ready, redirect, flush;
  logic [31:0] redirect_pc;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_resolved, stat_mispredict;
`endif

  int tests = 0;
  int fails = 0;

  branch_resolve #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid  (pred_valid),
    .pred_ready  (pred_ready),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .stat_resolved   (stat_resolved),
    .stat_mispredict (stat_mispredict)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t        m_q[$];
  bit          m_flush;
  logic [31:0] m_rpc;
  int unsigned m_res, m_mis;

  task automatic model_reset();
    m_q.delete();
    m_flush = 0;
    m_rpc   = 32'h0;
    m_res   = 0;
    m_mis   = 0;
  endtask

  task automatic model_step(input logic pv, input logic [31:0] ppc, input logic pt,
                            input logic [31:0] ptgt, input logic rv, input logic rt,
                            input logic [31:0] rtgt);
    bit   pr, rr, mis;
    ent_t h, n;
    pr  = !m_flush && (m_q.size() < DEPTH);
    rr  = !m_flush && (m_q.size() != 0);
    mis = 0;
    if (m_flush) begin
      m_flush = 0;
    end else begin
      if (rv && rr) begin
        h = m_q[0];
        m_res++;
        mis = (h.taken != rt) || (rt && h.target != rtgt);
        if (mis) begin
          m_mis++;
          m_rpc = rt ? rtgt : h.pc + 32'd4;
          m_q.delete();
          m_flush = 1;
        end else begin
          void'(m_q.pop_front());
        end
      end
      if (pv && pr && !mis) begin
        n.pc = ppc; n.taken = pt; n.target = ptgt;
        m_q.push_back(n);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_redirect",    {31'd0, redirect},   {31'd0, m_flush});
    chk("m_flush",       {31'd0, flush},      {31'd0, m_flush});
    chk("m_pred_ready",  {31'd0, pred_ready}, {31'd0, !m_flush && m_q.size() < DEPTH});
    chk("m_res_ready",   {31'd0, res_ready},  {31'd0, !m_flush && m_q.size() != 0});
    chk("m_redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("m_stat_resolved",   stat_resolved,   m_res);
    chk("m_stat_mispredict", stat_mispredict, m_mis);
`endif
  endtask

  // Inputs applied 1 time unit after a rising edge; outputs sampled likewise.
  task automatic cyc(input logic pv, input logic [31:0] ppc, input logic pt,
                     input logic [31:0] ptgt, input logic rv, input logic rt,
                     input logic [31:0] rtgt);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt;
    res_valid = rv; res_taken = rt; res_target = rtgt;
    model_step(pv, ppc, pt, ptgt, rv, rt, rtgt);
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        pt;
    logic [31:0] ptgt;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_pr;
    logic        e_rr;
  } vec_t;

  function automatic vec_t mk(logic pv, logic [31:0] ppc, logic pt, logic [31:0] ptgt,
                              logic rv, logic rt, logic [31:0] rtgt,
                              logic e_redir, logic [31:0] e_rpc, logic e_pr, logic e_rr);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.pt = pt; v.ptgt = ptgt;
    v.rv = rv; v.rt = rt; v.rtgt = rtgt;
    v.e_redir = e_redir; v.e_rpc = e_rpc; v.e_pr = e_pr; v.e_rr = e_rr;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    logic        pv, pt, rv, rt;
    logic [31:0] ppc, ptgt, rtgt;

    // correct prediction
    vecs[0]  = mk(1, 32'h3000, 1, 32'h2FFC, 0, 0, 0,          0, 0, 1, 1);
    vecs[1]  = mk(0, 0, 0, 0,               1, 1, 32'h2FFC,   0, 0, 1, 0);
    // direction mispredict
    vecs[2]  = mk(1, 32'h3000, 0, 32'h0,    0, 0, 0,          0, 0, 1, 1);
    vecs[3]  = mk(0, 0, 0, 0,               1, 1, 32'h3040,   1, 32'h3040, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,               0, 0, 0,          0, 0, 1, 0);
    // not-taken fallthrough wraps to zero
    vecs[5]  = mk(1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, 0,       0, 0, 1, 1);
    vecs[6]  = mk(0, 0, 0, 0,               1, 0, 32'h0,      1, 32'h0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0,               0, 0, 0,          0, 0, 1, 0);
    // target mispredict with a wrong-path push in the resolve cycle
    vecs[8]  = mk(1, 32'h2000, 1, 32'h2020, 0, 0, 0,          0, 0, 1, 1);
    vecs[9]  = mk(1, 32'h5000, 0, 32'h0,    1, 1, 32'h2040,   1, 32'h2040, 0, 0);
    vecs[10] = mk(0, 0, 0, 0,               0, 0, 0,          0, 0, 1, 0);
    // fill to DEPTH, then push+pop while full, then mispredict the 3rd
    vecs[11] = mk(1, 32'h100, 0, 32'h0,     0, 0, 0,          0, 0, 1, 1);
    vecs[12] = mk(1, 32'h200, 0, 32'h0,     0, 0, 0,          0, 0, 1, 1);
    vecs[13] = mk(1, 32'h300, 1, 32'h400,   0, 0, 0,          0, 0, 1, 1);
    vecs[14] = mk(1, 32'h500, 0, 32'h0,     0, 0, 0,          0, 0, 0, 1);
    vecs[15] = mk(1, 32'h600, 0, 32'h0,     1, 0, 32'h0,      0, 0, 1, 1);
    vecs[16] = mk(0, 0, 0, 0,               1, 0, 32'h0,      0, 0, 1, 1);
    vecs[17] = mk(0, 0, 0, 0,               1, 0, 32'h0,      1, 32'h304, 0, 0);
    vecs[18] = mk(0, 0, 0, 0,               0, 0, 0,          0, 0, 1, 0);
    // resolve on an empty queue is ignored
    vecs[19] = mk(0, 0, 0, 0,               1, 1, 32'h777,    0, 0, 1, 0);

    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    rst = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_redirect",    {31'd0, redirect},   32'd0);
    chk("rst_flush",       {31'd0, flush},      32'd0);
    chk("rst_redirect_pc", redirect_pc,         32'd0);
    chk("rst_pred_ready",  {31'd0, pred_ready}, 32'd1);
    chk("rst_res_ready",   {31'd0, res_ready},  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].pv, vecs[i].ppc, vecs[i].pt, vecs[i].ptgt,
          vecs[i].rv, vecs[i].rt, vecs[i].rtgt);
      chk($sformatf("v%0d_redirect", i),   {31'd0, redirect},   {31'd0, vecs[i].e_redir});
      chk($sformatf("v%0d_flush", i),      {31'd0, flush},      {31'd0, vecs[i].e_redir});
      chk($sformatf("v%0d_pred_ready", i), {31'd0, pred_ready}, {31'd0, vecs[i].e_pr});
      chk($sformatf("v%0d_res_ready", i),  {31'd0, res_ready},  {31'd0, vecs[i].e_rr});
      if (vecs[i].e_redir)
        chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
    end
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("tbl_stat_resolved",   stat_resolved,   32'd7);
    chk("tbl_stat_mispredict", stat_mispredict, 32'd4);
`endif

    // reset mid-queue: three entries pending, reset asserted between edges
    cyc(1, 32'h1000, 0, 0, 0, 0, 0);
    cyc(1, 32'h1004, 0, 0, 0, 0, 0);
    cyc(1, 32'h1008, 0, 0, 0, 0, 0);
    pred_valid = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_pred_ready", {31'd0, pred_ready}, 32'd1);
    chk("mid_rst_res_ready",  {31'd0, res_ready},  32'd0);
    chk("mid_rst_redirect",   {31'd0, redirect},   32'd0);
    chk("mid_rst_rpc",        redirect_pc,         32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 1, 1, 32'h9999);
    chk("post_rst_redirect",  {31'd0, redirect},   32'd0);
    chk("post_rst_res_ready", {31'd0, res_ready},  32'd0);
    chk("post_rst_pred_ready",{31'd0, pred_ready}, 32'd1);
    chk_model();

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      pv   = ($urandom_range(0, 9) < 7);
      ppc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      pt   = $urandom_range(0, 1);
      ptgt = {28'h0, 4'($urandom_range(0, 3)), 2'b00} >> 2 << 2;
      rv   = $urandom_range(0, 1);
      if (m_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        rt   = ($urandom_range(0, 4) == 0) ? !m_q[0].taken : m_q[0].taken;
        rtgt = ($urandom_range(0, 4) == 0) ? m_q[0].target + 32'd4 : m_q[0].target;
      end else begin
        rt   = $urandom_range(0, 1);
        rtgt = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      cyc(pv, ppc, pt, ptgt, rv, rt, rtgt);
      chk_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Back end of the static branch prediction path. Queues every prediction made at decode by the target generator (JAL, JALR, backward-taken BR). Checks each prediction against the actual outcome computed in execute, in program order. On a mismatch, emits a one-cycle redirect and flush to fetch.

## Interface
Parameters:
- DEPTH, 4, in-flight prediction entries; power of two, at least 2
- XLEN, 32, PC/target width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- pred_valid  in  1  decode offers a prediction for a control-flow instruction
- pred_ready  out  1  queue can accept; push when pred_valid && pred_ready
- pred_pc  in  XLEN  PC of the predicted instruction
- pred_taken  in  1  predicted direction (target_taken from target generator)
- pred_target  in  XLEN  predicted target (ignored when pred_taken=0)
- res_valid  in  1  execute resolves the oldest queued instruction
- res_ready  out  1  oldest entry present; resolve when res_valid && res_ready
- res_taken  in  1  actual direction
- res_target  in  XLEN  actual target address
- redirect  out  1  one-cycle pulse: fetch must restart at redirect_pc
- redirect_pc  out  XLEN  corrected PC, valid while redirect=1
- flush  out  1  one-cycle pulse, coincident with redirect; kill younger instructions

## Operation
- FIFO of {pc, taken, target}.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy count is clog2(DEPTH)+1 bits.
- pred_ready = (state==RUN) && count<DEPTH. There is no full bypass: a simultaneous pop does not free a slot in the same cycle.
- res_ready = (state==RUN) && count!=0. res_valid while res_ready=0 is ignored.
- Mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
- Correct PC:
  - res_taken=1: res_target.
  - res_taken=0: head.pc + 4, modulo 2^XLEN (0xFFFF_FFFC → 0x0000_0000).
- State machine:
  - RUN, correct resolve: pop the head.
  - RUN, mispredicting resolve: clear the queue (count=0, pointers=0), latch the correct PC, go to FLUSH.
    - A push in the same cycle is discarded, because it is wrong-path.
  - FLUSH: redirect=1 and flush=1; pred_ready=0 and res_ready=0; unconditionally return to RUN next cycle.
- Simultaneous push and correct resolve in RUN: both take effect; count unchanged.
- Reset mid-operation: queue emptied, state=RUN, all outputs to reset values asynchronously.

## Timing
- Reset values:
  - redirect=0, flush=0, redirect_pc=0.
  - pred_ready=1 (queue empty, RUN).
  - res_ready=0.
- Latency:
  - Mispredicting resolve at edge N → redirect/flush high during cycle N+1 only.
  - Queue accepts pushes again from cycle N+2.
- Push at edge N → res_ready high in cycle N+1 (when previously empty).
- redirect_pc holds its value outside FLUSH. Consumers qualify it with redirect.
- All outputs are registered or derived from state/count only. There is no combinational path from res_* to redirect.

## Configuration
- BRANCH_RESOLVE_STATS_EN defined: adds outputs stat_resolved (32 bits) and stat_mispredict (32 bits).
  - stat_resolved increments on every resolve handshake.
  - stat_mispredict increments on every mispredicting resolve.
  - Both are 0 at reset and wrap modulo 2^32.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package/header alongside control_sel.vh:
  - State encodings BR_RES_RUN and BR_RES_FLUSH.
  - Instruction size constant INSN_BYTES = 4.
  - Queue entry field widths.
- One sub-module is natural: pred_fifo, a synchronous FIFO with DEPTH/width parameters, a clear input, full/empty flags, and no bypass. The compare, state machine and redirect logic stay in branch_resolve.

## Test plan
- Reset mid-queue: push 3 entries, assert rst → pred_ready=1, res_ready=0, redirect=0; a following resolve is ignored.
- Correct prediction: push {pc=0x3000, taken=1, target=0x2FFC}; resolve {taken=1, target=0x2FFC} → no redirect, queue empty next cycle.
- Direction mispredict: push {pc=0x3000, taken=0}; resolve {taken=1, target=0x3040} → redirect=1, flush=1, redirect_pc=0x3040 for exactly one cycle; pred_ready=0 in that cycle.
- Not-taken fallthrough wrap: push {pc=0xFFFF_FFFC, taken=1, target=0x10}; resolve taken=0 → redirect_pc=0x0000_0000.
- Target mispredict (JALR): push {pc=0x2000, taken=1, target=0x2020}; resolve {taken=1, target=0x2040} → redirect_pc=0x2040; a push in the resolve cycle is discarded (res_ready=0 after FLUSH).
- Full/ordering: with DEPTH=4, push 4 → pred_ready=0; push+pop in the same cycle → push rejected; resolve 4 in order, mispredicting the 3rd → redirect uses entry 3; entry 4 is dropped; with BRANCH_RESOLVE_STATS_EN, stat_resolved=3 and stat_mispredict=1.
